// File: rtl/a3_ctl_pkg.sv
// Shared definitions for the control-unit instruction sequencer.
// The opcodes here mirror the control unit's parameter defaults.
package a3_ctl_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned REG_W = 6;
  localparam int unsigned IMM_W = 64;

  localparam logic [OP_W-1:0] CTL_NOP      = 8'h00;
  localparam logic [OP_W-1:0] CTL_LOAD_IMM = 8'h01;

  typedef enum logic [1:0] {
    S_OP,
    S_REG,
    S_IMM,
    S_ISSUE
  } ctl_seq_state_t;

endpackage

// File: rtl/ctl_seq.sv
// Byte-stream instruction sequencer: assembles opcode, register and immediate
// fields and issues each load-immediate to the control unit as a one-cycle strobe.
module ctl_seq #(
  parameter logic [7:0]  CTL_NOP      = a3_ctl_pkg::CTL_NOP,
  parameter logic [7:0]  CTL_LOAD_IMM = a3_ctl_pkg::CTL_LOAD_IMM,
  parameter int unsigned IMM_BYTES    = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       bus_in,
  input  logic             bus_valid,
  output logic             bus_ready,
  input  logic             hold,
  output logic [7:0]       ctl_op,
  output logic [5:0]       reg_sel,
  output logic [63:0]      imm,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] issued_cnt
);

  import a3_ctl_pkg::*;

  localparam logic [2:0] LAST_IDX = 3'(IMM_BYTES - 1);

  ctl_seq_state_t   state_q;
  logic [2:0]       byte_cnt_q;
  logic [5:0]       reg_pend_q;
  logic [63:0]      imm_buf_q;
  logic [7:0]       ctl_op_q;
  logic [5:0]       reg_sel_q;
  logic [63:0]      imm_q;
  logic             err_q;
  logic [CNT_W-1:0] issued_cnt_q;
  logic             accept;

  assign bus_ready  = !hold && (state_q != S_ISSUE);
  assign accept     = bus_valid && bus_ready;
  assign busy       = (state_q != S_OP);
  assign ctl_op     = ctl_op_q;
  assign reg_sel    = reg_sel_q;
  assign imm        = imm_q;
  assign err        = err_q;
  assign issued_cnt = issued_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OP;
      byte_cnt_q   <= '0;
      reg_pend_q   <= '0;
      imm_buf_q    <= '0;
      ctl_op_q     <= CTL_NOP;
      reg_sel_q    <= '0;
      imm_q        <= '0;
      err_q        <= 1'b0;
      issued_cnt_q <= '0;
    end else begin
      // Strobe is one cycle wide; only the issue branch overrides this.
      ctl_op_q <= CTL_NOP;
      unique case (state_q)
        S_OP: begin
          if (accept) begin
            if (bus_in == CTL_LOAD_IMM) begin
              state_q <= S_REG;
            end else if (bus_in != CTL_NOP) begin
              err_q <= 1'b1;
            end
          end
        end
        S_REG: begin
          if (accept) begin
            reg_pend_q <= bus_in[5:0];
            if (bus_in[7:6] != 2'b00) err_q <= 1'b1;
            imm_buf_q  <= '0;
            byte_cnt_q <= '0;
            state_q    <= S_IMM;
          end
        end
        S_IMM: begin
          if (accept) begin
            // Little-endian: first immediate byte lands in bits [7:0].
            imm_buf_q[{byte_cnt_q, 3'b000} +: 8] <= bus_in;
            byte_cnt_q <= byte_cnt_q + 3'd1;
            if (byte_cnt_q == LAST_IDX) state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!hold) begin
            ctl_op_q     <= CTL_LOAD_IMM;
            reg_sel_q    <= reg_pend_q;
            imm_q        <= imm_buf_q;
            issued_cnt_q <= issued_cnt_q + 1'b1;
            state_q      <= S_OP;
          end
        end
      endcase
    end
  end

endmodule
